// File: rtl/cache_fill_pkg.sv
// Shared state type, default line/channel geometry and helpers for the cache miss-fill arbiter.
package cache_fill_pkg;

    localparam int DEF_N_CH  = 2;
    localparam int DEF_WORDS = 8;
    localparam int OFF_W     = $clog2(DEF_WORDS);
    localparam int CH_W      = $clog2(DEF_N_CH);
    localparam int MAX_CH    = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } fill_state_t;

    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fill_arb_pick.sv
// Combinational winner selection for the miss-fill arbiter.
// FILL_ARB_RR_EN enables the rotating search from ptr; otherwise the lowest requesting index wins.
module fill_arb_pick
    import cache_fill_pkg::*;
#(
    parameter int N_CH = 2**CH_W,
    parameter int PW   = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            mode,
    output logic [N_CH-1:0] win
);

`ifdef FILL_ARB_RR_EN
    logic [N_CH-1:0] rot;
    logic [N_CH-1:0] rot_win;
    logic [N_CH-1:0] fixed_win;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot       = N_CH'({req, req} >> ptr);
        rot_win   = rot & (~rot + 1'b1);
        fixed_win = req & (~req + 1'b1);
        win       = mode ? N_CH'(({rot_win, rot_win} << ptr) >> N_CH) : fixed_win;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{ptr, mode};

    always_comb begin
        win = req & (~req + 1'b1);
    end
`endif

endmodule

// File: rtl/cache_fill_arb.sv
// Miss-fill engine: grants one cache channel at a time and streams a full line from shared memory.
// Macro FILL_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (channel 0 wins).
module cache_fill_arb
    import cache_fill_pkg::*;
#(
    parameter int N_CH   = 2**CH_W,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 2**OFF_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        miss_req,
    input  logic [N_CH*ADDR_W-1:0] miss_addr,
    output logic [N_CH-1:0]        grant,
    output logic                   busy,
    output logic                   fill_we,
    output logic [ADDR_W-1:0]      fill_addr,
    output logic [DATA_W-1:0]      fill_data,
    output logic [N_CH-1:0]        fill_done,
    output logic                   mem_re,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_valid
);

    localparam int LW = $clog2(WORDS);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [LW-1:0] LAST = LW'(WORDS - 1);

    fill_state_t          state;
    logic [ADDR_W-LW-1:0] tag;
    logic [LW-1:0]        k;
    logic [N_CH-1:0]      win;
    logic [ADDR_W-1:0]    sel_addr;
    logic [PW-1:0]        ptr;
    logic                 mode;
    logic                 accept;

    fill_arb_pick #(
        .N_CH (N_CH),
        .PW   (PW)
    ) u_pick (
        .req  (miss_req),
        .ptr  (ptr),
        .mode (mode),
        .win  (win)
    );

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (win[i]) sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign accept    = (state == WAIT) && mem_valid;
    assign fill_we   = accept;
    // Line address is kept as {tag, k} so the word offset can never carry into the tag.
    assign fill_addr = accept ? {tag, k} : '0;
    assign fill_data = accept ? mem_rdata : '0;
    assign fill_done = (accept && k == LAST) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            tag      <= '0;
            k        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|miss_req) begin
                        grant    <= win;
                        tag      <= sel_addr[ADDR_W-1:LW];
                        k        <= '0;
                        mem_re   <= 1'b1;
                        mem_addr <= {sel_addr[ADDR_W-1:LW], {LW{1'b0}}};
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_re <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (k == LAST) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            k        <= k + 1'b1;
                            mem_re   <= 1'b1;
                            mem_addr <= {tag, k + 1'b1};
                            state    <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FILL_ARB_RR_EN
    assign mode = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && k == LAST) begin
            ptr <= PW'((onehot_to_idx(MAX_CH'(grant)) + 1) % N_CH);
        end
    end
`else
    assign mode = 1'b0;
    assign ptr  = '0;
`endif

endmodule

// File: doc/cache_fill_arb.md
Name: cache_fill_arb

Overview:
- Parametrised miss-fill engine and arbiter between N_CH cache controllers (I-cache, D-cache, ...) and one shared multi-cycle main memory.
- Accepts line-miss requests, grants one channel at a time, fetches a full line word by word, and streams each word back to the granted cache with a write strobe.
- Successor to the fixed two-cache (I/D) fill control: width, line size and channel count are parametrised, and the arbitration mode is selectable.

Parameters:
- N_CH, 2, number of requesting caches; channel 0 is D-cache by convention.
- ADDR_W, 16, word address width.
- DATA_W, 16, memory word width.
- WORDS, 8, words per cache line; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  N_CH  per-channel miss request; held high until that channel's fill_done.
- miss_addr  in  N_CH*ADDR_W  flattened miss word addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- grant  out  N_CH  one-hot; channel currently being filled.
- busy  out  1  high in any state other than IDLE.
- fill_we  out  1  cache write strobe for the granted channel.
- fill_addr  out  ADDR_W  word address being written.
- fill_data  out  DATA_W  word being written.
- fill_done  out  N_CH  one-cycle pulse, one-hot, on the final word.
- mem_re  out  1  memory read request; one-cycle pulse.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data.
- mem_valid  in  1  mem_rdata valid; arrives at least 1 cycle after mem_re.

Behaviour:
- Reset is asynchronous, active-high, and clears everything immediately: state to IDLE; grant, busy, fill_we, fill_done and mem_re to 0; fill_addr, fill_data and mem_addr to 0; word counter to 0; round-robin pointer to 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If miss_req != 0, pick a winner and register its one-hot grant.
  - Latch base = miss_addr[winner] with the low log2(WORDS) bits cleared; set k = 0; go to ISSUE.
  - No memory activity in the same cycle as the pick.
- ISSUE:
  - mem_re = 1 for exactly one cycle, with mem_addr = base + k.
  - Go to WAIT.
- WAIT:
  - mem_re = 0; hold until mem_valid.
  - On the mem_valid cycle, combinationally: fill_we = 1, fill_data = mem_rdata, fill_addr = base + k.
  - If k == WORDS-1: assert fill_done[granted] in that same cycle, clear grant at the edge, go to IDLE.
  - Otherwise: k increments and the next state is ISSUE.
- Line timing: with a 1-cycle memory, a line completes 2*WORDS cycles after the grant edge.
- Address rule: the offset addition never carries into the tag bits; base + k wraps only within the line.
- miss_req for the granted channel deasserting mid-fill is ignored; the fill completes and fill_done still pulses.
- New requests arriving during a fill wait; they are sampled only in IDLE.
- mem_valid outside WAIT is ignored: no fill_we, no state change.
- Requesters drop miss_req on the edge after fill_done, so IDLE never re-grants a served line.
- Reset mid-fill: the fill is abandoned, no fill_done is issued, and the requester must re-request.

Optional Feature:
- Macro: FILL_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at the pointer; after each completed fill the pointer becomes (granted index + 1) mod N_CH. An abandoned fill does not move the pointer.
- Undefined: fixed priority, lowest index wins, so the D-cache beats the I-cache. The pointer logic is removed.

Decomposition:
- Package cache_fill_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - localparams OFF_W = $clog2(WORDS) and CH_W = $clog2(N_CH);
  - the function onehot_to_idx.
- Sub-module fill_arb_pick: combinational winner selection, taking req, pointer and a mode input, and producing a one-hot winner. It is the only block affected by FILL_ARB_RR_EN.

Test Plan:
- Single line fill:
  - Stimulus: ch0 requests 0x1234; memory returns (addr ^ 0xA5A5) one cycle after mem_re.
  - Response: eight fill_we pulses, with fill_addr 0x1230..0x1237 and matching data.
  - fill_done[0] pulses 16 cycles after the grant edge.
  - mem_re pulses exactly 8 times.
- Simultaneous requests:
  - Stimulus: ch0 and ch1 request at the same cycle.
  - Fixed priority: ch0 is filled first, then ch1.
  - With FILL_ARB_RR_EN: ch0 then ch1; a following simultaneous pair grants ch0 again, since the pointer wrapped to 0.
  - Each grant runs to its own fill_done.
- Slow memory:
  - Stimulus: mem_valid 4 cycles after mem_re.
  - Response: mem_re is a single pulse per word and busy stays high.
  - The line takes 5*8 = 40 cycles.
- Reset mid-fill:
  - Stimulus: rst asserted after 3 words have been written.
  - Response: all outputs are 0 asynchronously and no fill_done is issued.
  - After release, a new ch1 request to 0x0040 starts at word 0x0040.
- Spurious and dropped inputs:
  - Spurious: mem_valid pulses while IDLE produce no fill_we.
  - Dropped: ch1 drops miss_req at word 2; the fill still completes and fill_done[1] still pulses.
